// File: rtl/gamepad_pkg.sv
// gamepad_pkg: shared definitions for the gamepad scan controller.
//   state_t : scan scheduler FSM encoding
//   EVT_*   : bit layout of one press/release event word
package gamepad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SCAN = 2'd2,
    ST_CMP  = 2'd3
  } state_t;

  localparam int EVT_PAD_LSB   = 32;
  localparam int EVT_PRESS_LSB = 16;
  localparam int EVT_REL_LSB   = 0;
  localparam int EVT_W         = 36;

endpackage

// File: rtl/gamepad_evt_fifo.sv
// gamepad_evt_fifo: show-ahead synchronous FIFO, drop-on-full.
//   clk, rst_n      : clock, async active-low reset
//   push, push_data : write request; dropped (drop=1) when full with no pop
//   pop, pop_data   : pop request (ignored when empty); pop_data = head
//   empty, level    : status
//   drop            : one-cycle pulse, a push was discarded
module gamepad_evt_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] cnt;
  logic          full, do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;

  assign pop_data = mem[rd_ptr];
  assign level    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/gamepad_scan_ctrl.sv
// gamepad_scan_ctrl: frame-periodic scan scheduler, debounce and event
// generator for the gamepad shift core.
//   cfg_en/cfg_period/cfg_deb : enable, frame period (period+1 cycles), debounce
//   scan_start / scan_done    : handshake with core (single-shot scan)
//   gp_value                  : raw pad words, pad p at [16p+:16]
//   pad_state                 : debounced stable words
//   evt_*                     : event FIFO (show-ahead), irq = evt_valid
//   ovf / overrun / sts_clr   : sticky status flags and their clear
module gamepad_scan_ctrl
  import gamepad_pkg::*;
#(
  parameter int N_PADS     = 4,
  parameter int PERIOD_W   = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_en,
  input  logic [PERIOD_W-1:0]           cfg_period,
  input  logic                          cfg_deb,
  output logic                          scan_start,
  input  logic                          scan_done,
  input  logic [16*N_PADS-1:0]          gp_value,
  output logic [16*N_PADS-1:0]          pad_state,
  output logic                          evt_valid,
  output logic [EVT_W-1:0]              evt_data,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   evt_level,
  output logic                          ovf,
  output logic                          overrun,
  input  logic                          sts_clr,
  output logic                          irq
);

  localparam int PIDX_W = (N_PADS > 1) ? $clog2(N_PADS) : 1;

  state_t                   state;
  logic [PERIOD_W-1:0]      timer;
  logic [N_PADS-1:0][15:0]  snap, hist, pad_q;
  logic [PIDX_W-1:0]        pad_idx;
  logic                     tick, last_pad, accept, push, drop, empty;
  logic [15:0]              cand, cur, pressed, released;
  logic [EVT_W-1:0]         push_data;

  // Timer free-runs outside IDLE so the frame rate is independent of scan length.
  assign tick     = cfg_en && (timer == '0) && (state != ST_IDLE);
  assign last_pad = (pad_idx == PIDX_W'(N_PADS - 1));

  assign cand     = snap[pad_idx];
  assign cur      = pad_q[pad_idx];
  // With debounce, a word differing from the previous raw scan is only noted.
  assign accept   = !(cfg_deb && (cand != hist[pad_idx]));
  assign pressed  = cand & ~cur;
  assign released = ~cand & cur;
  assign push     = (state == ST_CMP) && accept && ((pressed | released) != 16'h0);

  always_comb begin
    push_data = '0;
    push_data[EVT_PAD_LSB +: 4]    = 4'(pad_idx);
    push_data[EVT_PRESS_LSB +: 16] = pressed;
    push_data[EVT_REL_LSB +: 16]   = released;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   timer <= '0;
    else if ((state == ST_IDLE && cfg_en) || tick) timer <= cfg_period;
    else if (timer != '0)                         timer <= timer - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      scan_start <= 1'b0;
      snap       <= '0;
      hist       <= '0;
      pad_q      <= '0;
      pad_idx    <= '0;
      ovf        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      scan_start <= 1'b0;
      // Same-cycle set beats clear.
      ovf     <= (ovf & ~sts_clr) | drop;
      overrun <= (overrun & ~sts_clr) |
                 (tick && (state == ST_SCAN || state == ST_CMP));
      case (state)
        ST_IDLE: if (cfg_en) state <= ST_WAIT;
        ST_WAIT: begin
          if (!cfg_en) state <= ST_IDLE;
          else if (tick) begin
            scan_start <= 1'b1;
            state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (scan_done) begin
            snap    <= gp_value;
            pad_idx <= '0;
            state   <= ST_CMP;
          end
        end
        ST_CMP: begin
          hist[pad_idx] <= cand;
          if (accept) pad_q[pad_idx] <= cand;
          if (last_pad) state <= cfg_en ? ST_WAIT : ST_IDLE;
          else          pad_idx <= pad_idx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  gamepad_evt_fifo #(.W(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_ready),
    .pop_data  (evt_data),
    .empty     (empty),
    .level     (evt_level),
    .drop      (drop)
  );

  assign pad_state = pad_q;
  assign evt_valid = !empty;
  assign irq       = !empty;

endmodule

// File: doc/gamepad_scan_ctrl.md
Name: gamepad_scan_ctrl

Overview:
Scan scheduler and event generator for the gamepad serial-shift core. It triggers one controller scan per programmable frame period and captures the parallel button words. It debounces the words and turns changes into press/release events in a small FIFO, with a level IRQ. It sits between the gamepad core (single-shot scan mode) and the CPU-facing register block, so software no longer polls raw button words.

Parameters:
N_PADS, 4, number of 16-bit pad words on gp_value (1..16)
PERIOD_W, 20, width of cfg_period
FIFO_DEPTH, 8, event FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cfg_en  in  1  scanning enable
cfg_period  in  PERIOD_W  frame period; a scan is requested every cfg_period+1 cycles
cfg_deb  in  1  1 = a new raw word must be seen on 2 consecutive scans before it is accepted
scan_start  out  1  one-cycle pulse: core starts one scan
scan_done  in  1  one-cycle pulse from core: gp_value valid and stable
gp_value  in  16*N_PADS  raw pad words, pad p at [16p+:16], 1 = pressed
pad_state  out  16*N_PADS  debounced stable words
evt_valid  out  1  FIFO not empty
evt_data  out  36  [35:32] pad index, [31:16] newly pressed mask, [15:0] newly released mask
evt_ready  in  1  pop head when evt_valid=1
evt_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
ovf  out  1  sticky: an event was dropped (FIFO full)
overrun  out  1  sticky: a period tick arrived while a scan/compare was still in progress
sts_clr  in  1  clears ovf and overrun
irq  out  1  equals evt_valid

Behaviour:
- Reset, asynchronous on rst_n low: state IDLE, timer=0, scan_start=0, pad_state=0, raw history=0, FIFO empty, evt_valid=0, evt_level=0, ovf=0, overrun=0, irq=0. Reset mid-scan abandons the scan; a late scan_done is ignored in IDLE.
- Timer: down-counter, reloaded with cfg_period on entering WAIT and on each tick. Tick = timer==0 while cfg_en=1. cfg_period=0 gives a tick every cycle.
- FSM:
  IDLE: if cfg_en -> WAIT, timer loaded.
  WAIT: on tick -> assert scan_start for exactly 1 cycle, go to SCAN. If cfg_en=0 -> IDLE.
  SCAN: wait for scan_done; capture gp_value into snapshot register that cycle -> CMP with pad index=0. No timeout.
  CMP: one pad per cycle, p=0..N_PADS-1. Candidate c = snapshot[p].
    - If cfg_deb=1 and c != hist[p]: hist[p]<=c and no state change.
    - Otherwise: pressed = c & ~pad_state[p]; released = ~c & pad_state[p]; pad_state[p]<=c; hist[p]<=c. If pressed|released != 0, push {p, pressed, released}.
    - After the last pad: -> WAIT if cfg_en, else IDLE.
  - cfg_en falling during SCAN/CMP: the current scan and compare complete, then IDLE.
- Timer keeps running in SCAN/CMP. A tick there sets overrun, is not queued, and the timer reloads.
- Events from one scan are pushed in ascending pad order, at most one per pad.
- FIFO: show-ahead. evt_data is valid whenever evt_valid=1, and pop happens on evt_valid&evt_ready.
  - Push when full: event dropped, ovf<=1, FIFO unchanged.
  - Push and pop in the same cycle when full: both succeed and the level is unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- sts_clr has priority below a same-cycle set: if set and clear coincide, the flag ends at 1.
- Latency: scan_done at cycle t -> first event visible on evt_valid at t+2. Pad p is evaluated at t+1+p and its event is visible from t+2+p.

Decomposition:
- Package gamepad_pkg: FSM state encoding (IDLE/WAIT/SCAN/CMP) and the event field offsets (EVT_PAD_LSB=32, EVT_PRESS_LSB=16, EVT_REL_LSB=0, EVT_W=36).
- One sub-module, gamepad_evt_fifo: synchronous FIFO with async active-low reset, parameterised by width/depth, with full/empty/level and drop-on-full reporting. The FSM, timer and debounce stay in the top.

Test Plan:
- cfg_en=1, cfg_period=99, scan_done 10 cycles after each scan_start -> scan_start pulses exactly 100 cycles apart, each 1 cycle wide. No overrun.
- cfg_deb=0, N_PADS=4, pad2 raw 0x0000→0x0011 -> one event {2, 0x0011, 0x0000} at scan_done+4, and pad_state[47:32]=0x0011. The next identical scan produces no event.
- cfg_deb=1, pad0 0x0000→0x0001 for one scan then back to 0x0000 -> no event and pad_state unchanged. When 0x0001 is held for 2 scans -> event {0, 0x0001, 0} after the second scan.
- FIFO_DEPTH=8, evt_ready=0, 9 change events pushed -> evt_level=8 and ovf=1. The first 8 events pop in order. sts_clr -> ovf=0.
- cfg_period=3, scan_done delayed 20 cycles -> overrun=1, no extra scan_start during the scan, and the next scan_start follows the next tick after CMP.
- rst_n asserted low mid-CMP with 3 events queued -> outputs return to reset values immediately (async), irq=0, and a scan_done pulse after release is ignored.
